// File: rtl/bramsd_be_if.sv
// Semi-dual-port RAM bus: write port, read port and read-return signals.
interface bramsd_be_if #(
  parameter int ADDR_ = 8,
  parameter int DATA_ = 32,
  parameter int BYTE_ = 8
);
  localparam int NBE = DATA_ / BYTE_;

  logic             we;
  logic [ADDR_-1:0] waddr;
  logic [DATA_-1:0] din;
  logic [NBE-1:0]   wbe;
  logic             re;
  logic [ADDR_-1:0] raddr;
  logic [DATA_-1:0] dout;
  logic             dvalid;

  modport master (output we, waddr, din, wbe, re, raddr, input dout, dvalid);
  modport slave  (input we, waddr, din, wbe, re, raddr, output dout, dvalid);
endinterface

// File: rtl/bramsd_be.sv
// Semi-dual-port block RAM: per-byte write enables, read-valid strobe,
// read latency 1 or 2, and a selectable same-address read-during-write policy.
// Storage is split into one byte-wide array per lane.

// One byte lane: storage plus first read register.
module bramsd_be_lane #(
  parameter int ADDR_ = 8,
  parameter int BYTE_ = 8,
  parameter     RDW_  = "NEW"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ADDR_-1:0] waddr,
  input  logic [BYTE_-1:0] din,
  input  logic             re,
  input  logic [ADDR_-1:0] raddr,
  output logic [BYTE_-1:0] q
);
  // Zero at configuration; reset deliberately never touches the array.
  logic [BYTE_-1:0] mem [2**ADDR_] = '{default: '0};

  // Lane write; ignored while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && we) mem[waddr] <= din;
  end

  // Read register; forwards din on a same-address collision in NEW mode,
  // otherwise the array still holds the pre-write contents at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (re) begin
      if (RDW_ == "NEW" && we && (waddr == raddr)) q <= din;
      else                                         q <= mem[raddr];
    end
  end
endmodule

module bramsd_be #(
  parameter int ADDR_ = 8,
  parameter int DATA_ = 32,
  parameter int BYTE_ = 8,
  parameter int LAT_  = 1,
  parameter     RDW_  = "NEW"
) (
  input  logic         clk,
  input  logic         rst_n,
  bramsd_be_if.slave   bus
);
  localparam int NBE = DATA_ / BYTE_;

  if (DATA_ % BYTE_ != 0) begin : g_bad_byte
    $error("bramsd_be: DATA_ must be a multiple of BYTE_");
  end
  if (LAT_ != 1 && LAT_ != 2) begin : g_bad_lat
    $error("bramsd_be: LAT_ must be 1 or 2");
  end
  if (RDW_ != "NEW" && RDW_ != "OLD") begin : g_bad_rdw
    $error("bramsd_be: RDW_ must be \"NEW\" or \"OLD\"");
  end

  logic [NBE-1:0][BYTE_-1:0] din_l;
  logic [NBE-1:0][BYTE_-1:0] rd1;
  logic [LAT_:0]             vld_pipe;

  assign din_l       = bus.din;
  assign vld_pipe[0] = bus.re;

  for (genvar g = 0; g < NBE; g++) begin : g_lane
    bramsd_be_lane #(.ADDR_(ADDR_), .BYTE_(BYTE_), .RDW_(RDW_)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bus.we & bus.wbe[g]),
      .waddr (bus.waddr),
      .din   (din_l[g]),
      .re    (bus.re),
      .raddr (bus.raddr),
      .q     (rd1[g])
    );
  end

  // Read-valid shift register tracking each issued read through the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[LAT_:1] <= '0;
    else        vld_pipe[LAT_:1] <= vld_pipe[LAT_-1:0];
  end

  if (LAT_ == 2) begin : g_lat2
    logic [DATA_-1:0] rd2;
    // Output register; loads only when stage 1 holds a fresh read so dout
    // keeps the last result between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          rd2 <= '0;
      else if (vld_pipe[1]) rd2 <= rd1;
    end
    assign bus.dout = rd2;
  end else begin : g_lat1
    assign bus.dout = rd1;
  end

  assign bus.dvalid = vld_pipe[LAT_];
endmodule

// File: tb/tb_bramsd_be.sv
// Directed bench: DUT a = LAT_1/NEW, DUT b = LAT_2/OLD, shared stimulus.
module tb_bramsd_be;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0, re = 1'b0;
  logic [7:0]  waddr = '0, raddr = '0;
  logic [31:0] din = '0;
  logic [3:0]  wbe = '0;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  bramsd_be_if #(.ADDR_(8), .DATA_(32), .BYTE_(8)) a_if ();
  bramsd_be_if #(.ADDR_(8), .DATA_(32), .BYTE_(8)) b_if ();

  assign a_if.we = we;  assign a_if.waddr = waddr; assign a_if.din = din;
  assign a_if.wbe = wbe; assign a_if.re = re;     assign a_if.raddr = raddr;
  assign b_if.we = we;  assign b_if.waddr = waddr; assign b_if.din = din;
  assign b_if.wbe = wbe; assign b_if.re = re;     assign b_if.raddr = raddr;

  bramsd_be #(.ADDR_(8), .DATA_(32), .BYTE_(8), .LAT_(1), .RDW_("NEW"))
    u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  bramsd_be #(.ADDR_(8), .DATA_(32), .BYTE_(8), .LAT_(2), .RDW_("OLD"))
    u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = a; din = d; wbe = be;
  endtask

  initial begin
    // Reset with both ports active.
    rst_n = 1'b0; re = 1'b1; raddr = 8'd0; wr(8'd0, 32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_a_dout", a_if.dout, 32'h0);   chk("rst_a_dv", {31'b0, a_if.dvalid}, 32'h0);
      chk("rst_b_dout", b_if.dout, 32'h0);   chk("rst_b_dv", {31'b0, b_if.dvalid}, 32'h0);
    end
    rst_n = 1'b1; re = 1'b0; we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_a_dv", {31'b0, a_if.dvalid}, 32'h0);
      chk("idle_b_dv", {31'b0, b_if.dvalid}, 32'h0);
    end

    // Write during reset was ignored: addr 0 reads zero.
    re = 1'b1; raddr = 8'd0; tick(); re = 1'b0;
    chk("rstwr_a", a_if.dout, 32'h0);
    tick();
    chk("rstwr_b", b_if.dout, 32'h0);

    // Byte-lane merge.
    wr(8'd5, 32'hAABBCCDD, 4'b1111); tick();
    wr(8'd5, 32'h11223344, 4'b0101); tick();
    wr(8'd6, 32'h12345678, 4'b0000); tick();   // all-zero wbe is a no-op
    we = 1'b0; re = 1'b1; raddr = 8'd5; tick();
    chk("be_a_dout", a_if.dout, 32'hAA22CC44); chk("be_a_dv", {31'b0, a_if.dvalid}, 32'h1);
    chk("be_b_dv0", {31'b0, b_if.dvalid}, 32'h0);
    raddr = 8'd6; tick(); re = 1'b0;
    chk("nobe_a", a_if.dout, 32'h0);
    chk("be_b_dout", b_if.dout, 32'hAA22CC44); chk("be_b_dv", {31'b0, b_if.dvalid}, 32'h1);
    tick();
    chk("hold_a_dv", {31'b0, a_if.dvalid}, 32'h0); chk("hold_a_dout", a_if.dout, 32'h0);
    chk("nobe_b", b_if.dout, 32'h0);
    tick();
    chk("hold_b_dv", {31'b0, b_if.dvalid}, 32'h0); chk("hold_b_dout", b_if.dout, 32'h0);

    // Streaming fill and full-rate readback.
    for (int k = 0; k < 256; k++) begin wr(k[7:0], k, 4'hF); tick(); end
    we = 1'b0; re = 1'b1;
    for (int k = 0; k < 256; k++) begin
      raddr = k[7:0]; tick();
      chk("strm_a", a_if.dout, k); chk("strm_a_dv", {31'b0, a_if.dvalid}, 32'h1);
      if (k > 0) begin
        chk("strm_b", b_if.dout, k - 1); chk("strm_b_dv", {31'b0, b_if.dvalid}, 32'h1);
      end
    end
    re = 1'b0; tick();
    chk("strm_a_end", {31'b0, a_if.dvalid}, 32'h0);
    chk("strm_b_255", b_if.dout, 32'd255); chk("strm_b_dv_end", {31'b0, b_if.dvalid}, 32'h1);
    tick();

    // Same-address read during write.
    wr(8'd7, 32'h0, 4'hF); tick();
    wr(8'd7, 32'hFFFFFFFF, 4'b0011); re = 1'b1; raddr = 8'd7; tick();
    chk("rdw_a_new", a_if.dout, 32'h0000FFFF);
    we = 1'b0; tick();
    chk("rdw_a_after", a_if.dout, 32'h0000FFFF);
    chk("rdw_b_old", b_if.dout, 32'h00000000);
    re = 1'b0; tick();
    chk("rdw_b_after", b_if.dout, 32'h0000FFFF);

    // Different addresses on the same edge are independent.
    wr(8'd8, 32'hCAFEF00D, 4'hF); re = 1'b1; raddr = 8'd9; tick();
    we = 1'b0; re = 1'b0;
    chk("diff_a", a_if.dout, 32'd9);
    tick();
    chk("diff_b", b_if.dout, 32'd9);

    // A write after the issue edge does not affect that read.
    wr(8'd3, 32'h5, 4'hF); tick();
    we = 1'b0; re = 1'b1; raddr = 8'd3; tick();          // edge N
    re = 1'b0; wr(8'd3, 32'h9, 4'hF); tick();            // edge N+1
    chk("ord_b_old", b_if.dout, 32'h5); chk("ord_b_dv", {31'b0, b_if.dvalid}, 32'h1);
    we = 1'b0; re = 1'b1; raddr = 8'd3; tick();          // edge N+2
    chk("ord_a_new", a_if.dout, 32'h9);
    re = 1'b0; tick();
    chk("ord_b_new", b_if.dout, 32'h9);

    // Reset while a read is in flight.
    wr(8'd10, 32'h1234, 4'hF); tick(); we = 1'b0;
    re = 1'b1; raddr = 8'd10; tick();
    re = 1'b0; #2 rst_n = 1'b0; #1;
    chk("mid_a_dout", a_if.dout, 32'h0); chk("mid_a_dv", {31'b0, a_if.dvalid}, 32'h0);
    chk("mid_b_dout", b_if.dout, 32'h0); chk("mid_b_dv", {31'b0, b_if.dvalid}, 32'h0);
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_b_nodv", {31'b0, b_if.dvalid}, 32'h0);
      chk("mid_a_nodv", {31'b0, a_if.dvalid}, 32'h0);
    end
    re = 1'b1; raddr = 8'd10; tick(); re = 1'b0;
    chk("keep_a", a_if.dout, 32'h1234);
    tick();
    chk("keep_b", b_if.dout, 32'h1234); chk("keep_b_dv", {31'b0, b_if.dvalid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
